load_store_unit: RTL and testbench

//   Memory stage directly downstream of the ALU. Consumes the ALU result as an effective

---
 rtl/load_store_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I memory stage: lane steering, byte strobes and load extension over a req/ack port.
// Misaligned, illegal and timed-out ops produce a fault beat instead of a register write.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_rd_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic [31:0] wb_data,
  output logic        fault_valid,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic {S_IDLE, S_REQ} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [2:0]        op_f3_q, op_f3_d;
  logic [1:0]        op_off_q, op_off_d;
  logic [4:0]        op_rd_q, op_rd_d;
  logic              op_rd_we_q, op_rd_we_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_we_q, wb_we_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              fault_valid_q, fault_valid_d;
  logic [1:0]        fault_cause_q, fault_cause_d;
  logic [31:0]       fault_addr_q, fault_addr_d;

  logic              accept, is_mem, illegal, misaligned, rd_we_eff, timeout;
  logic [CNT_W-1:0]  cnt_inc;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;

  assign ex_ready = (state_q == S_IDLE) && !rst;
  assign accept   = ex_valid && (state_q == S_IDLE);
  assign is_mem   = ex_is_load || ex_is_store;
  assign rd_we_eff = ex_rd_we && (ex_rd != 5'd0);

  // Decode legality of the op presented in IDLE
  always_comb begin
    illegal = (ex_is_load && ex_is_store)
           || (ex_is_load && ((ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11)))
           || (ex_is_store && (ex_funct3[2] || (ex_funct3[1:0] == 2'b11)));
    misaligned = ((ex_funct3[1:0] == 2'b01) && ex_addr[0])
              || ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
  end

  // Load lane selection and extension
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (op_off_q)
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      2'd3:    ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = op_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign timeout = (TIMEOUT_CYCLES != 0) && (32'(cnt_inc) == TIMEOUT_CYCLES);

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wstrb_d   = mem_wstrb_q;
    op_f3_d       = op_f3_q;
    op_off_d      = op_off_q;
    op_rd_d       = op_rd_q;
    op_rd_we_d    = op_rd_we_q;
    wb_valid_d    = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_we_d       = 1'b0;
    wb_data_d     = wb_data_q;
    fault_valid_d = 1'b0;
    fault_cause_d = fault_cause_q;
    fault_addr_d  = fault_addr_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd;
            wb_we_d    = rd_we_eff;
            wb_data_d  = ex_addr;
          end else if (illegal || misaligned) begin
            wb_valid_d    = 1'b1;
            wb_rd_d       = ex_rd;
            fault_valid_d = 1'b1;
            fault_cause_d = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
            fault_addr_d  = ex_addr;
          end else begin
            state_d     = S_REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = ex_is_store;
            mem_addr_d  = {ex_addr[31:2], 2'b00};
            op_f3_d     = ex_funct3;
            op_off_d    = ex_addr[1:0];
            op_rd_d     = ex_rd;
            op_rd_we_d  = rd_we_eff && ex_is_load;
            mem_wstrb_d = 4'b0000;
            mem_wdata_d = ex_store_data;
            if (ex_is_store) begin
              case (ex_funct3[1:0])
                2'b00: begin
                  mem_wdata_d = {4{ex_store_data[7:0]}};
                  mem_wstrb_d = 4'b0001 << ex_addr[1:0];
                end
                2'b01: begin
                  mem_wdata_d = {2{ex_store_data[15:0]}};
                  mem_wstrb_d = ex_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: mem_wstrb_d = 4'b1111;
              endcase
            end
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d    = S_IDLE;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = op_rd_q;
          wb_we_d    = op_rd_we_q;
          if (!mem_we_q) wb_data_d = ld_data;
        end else if (timeout) begin
          state_d       = S_IDLE;
          mem_req_d     = 1'b0;
          wb_valid_d    = 1'b1;
          wb_rd_d       = op_rd_q;
          fault_valid_d = 1'b1;
          fault_cause_d = CAUSE_TIMEOUT;
          fault_addr_d  = {mem_addr_q[31:2], op_off_q};
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wstrb_q   <= '0;
      op_f3_q       <= '0;
      op_off_q      <= '0;
      op_rd_q       <= '0;
      op_rd_we_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_we_q       <= 1'b0;
      wb_data_q     <= '0;
      fault_valid_q <= 1'b0;
      fault_cause_q <= '0;
      fault_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wstrb_q   <= mem_wstrb_d;
      op_f3_q       <= op_f3_d;
      op_off_q      <= op_off_d;
      op_rd_q       <= op_rd_d;
      op_rd_we_q    <= op_rd_we_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_we_q       <= wb_we_d;
      wb_data_q     <= wb_data_d;
      fault_valid_q <= fault_valid_d;
      fault_cause_q <= fault_cause_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_we       = wb_we_q;
  assign wb_data     = wb_data_q;
  assign fault_valid = fault_valid_q;
  assign fault_cause = fault_cause_q;
  assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short timeout so the bus-timeout path is reachable.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_is_load, ex_is_store, ex_rd_we;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_store_data;
  logic [4:0]  ex_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, wb_we, fault_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, fault_addr;
  logic [1:0]  fault_cause;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .fault_valid(fault_valid), .fault_cause(fault_cause), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd, input logic we);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_addr = addr; ex_store_data = sdata; ex_rd = rd; ex_rd_we = we;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
  endtask

  // Accept a legal memory op, check the request, ack immediately, check the writeback
  task automatic mem_op(input string tag, input logic ld, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input logic [31:0] exp_maddr,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                        input logic exp_wbwe, input logic [31:0] exp_wbdata);
    present(ld, !ld, f3, addr, sdata, 5'd7, 1'b1);
    step();
    idle_ex();
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_we"}, 32'(mem_we), 32'(!ld));
    chk({tag, "_addr"}, mem_addr, exp_maddr);
    chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'(exp_wstrb));
    if (!ld) chk({tag, "_wdata"}, mem_wdata, exp_wdata);
    chk({tag, "_rdy"}, 32'(ex_ready), 32'd0);
    mem_ack = 1'b1; mem_rdata = rdata;
    step();
    mem_ack = 1'b0;
    chk({tag, "_reqdrop"}, 32'(mem_req), 32'd0);
    chk({tag, "_wbv"}, 32'(wb_valid), 32'd1);
    chk({tag, "_wbwe"}, 32'(wb_we), 32'(exp_wbwe));
    chk({tag, "_flt"}, 32'(fault_valid), 32'd0);
    if (ld) chk({tag, "_wbdata"}, wb_data, exp_wbdata);
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    ex_funct3 = '0; ex_addr = '0; ex_store_data = '0; ex_rd = '0; ex_rd_we = 1'b0;
    idle_ex();
    step(); step();
    chk("rst_rdy", 32'(ex_ready), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_fault", 32'(fault_valid), 32'd0);
    rst = 1'b0; #1;
    chk("rdy_after_rst", 32'(ex_ready), 32'd1);

    // ALU pass-through, back to back
    present(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
    step();
    chk("alu_wbv", 32'(wb_valid), 32'd1);
    chk("alu_data", wb_data, 32'h1234);
    chk("alu_rd", 32'(wb_rd), 32'd5);
    chk("alu_we", 32'(wb_we), 32'd1);
    present(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd0, 1'b1);
    step();
    idle_ex();
    chk("alu0_wbv", 32'(wb_valid), 32'd1);
    chk("alu0_we", 32'(wb_we), 32'd0);
    chk("alu0_data", wb_data, 32'h55);
    step();
    chk("alu_idle_wbv", 32'(wb_valid), 32'd0);

    // Loads
    mem_op("lb", 1'b1, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 32'h100, 32'h0, 4'b0000, 1'b1, 32'hFFFF_FF80);
    mem_op("lbu", 1'b1, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 32'h100, 32'h0, 4'b0000, 1'b1, 32'h0000_0080);
    mem_op("lh", 1'b1, 3'b001, 32'h102, 32'h0, 32'h80FF_0000, 32'h100, 32'h0, 4'b0000, 1'b1, 32'hFFFF_80FF);
    mem_op("lhu", 1'b1, 3'b101, 32'h102, 32'h0, 32'h80FF_0000, 32'h100, 32'h0, 4'b0000, 1'b1, 32'h0000_80FF);
    mem_op("lw", 1'b1, 3'b010, 32'h108, 32'h0, 32'h1357_9BDF, 32'h108, 32'h0, 4'b0000, 1'b1, 32'h1357_9BDF);
    mem_op("lb1", 1'b1, 3'b000, 32'h101, 32'h0, 32'h0000_7F00, 32'h100, 32'h0, 4'b0000, 1'b1, 32'h0000_007F);
    // Stores
    mem_op("sh", 1'b0, 3'b001, 32'h202, 32'hDEAD_BEEF, 32'h0, 32'h200, 32'hBEEF_BEEF, 4'b1100, 1'b0, 32'h0);
    mem_op("sb", 1'b0, 3'b000, 32'h201, 32'h1234_56EF, 32'h0, 32'h200, 32'hEFEF_EFEF, 4'b0010, 1'b0, 32'h0);
    mem_op("sw", 1'b0, 3'b010, 32'h204, 32'hCAFE_F00D, 32'h0, 32'h204, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0);

    // Misaligned and illegal ops fault without touching memory
    present(1'b1, 1'b0, 3'b010, 32'h301, 32'h0, 5'd9, 1'b1);
    step();
    idle_ex();
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_flt", 32'(fault_valid), 32'd1);
    chk("mis_cause", 32'(fault_cause), 32'd1);
    chk("mis_addr", fault_addr, 32'h301);
    chk("mis_wbv", 32'(wb_valid), 32'd1);
    chk("mis_wbwe", 32'(wb_we), 32'd0);
    present(1'b1, 1'b0, 3'b011, 32'h300, 32'h0, 5'd9, 1'b1);
    step();
    chk("ill_f3_cause", 32'(fault_cause), 32'd2);
    chk("ill_f3_flt", 32'(fault_valid), 32'd1);
    present(1'b1, 1'b1, 3'b010, 32'h300, 32'h0, 5'd9, 1'b1);
    step();
    chk("ill_ldst_cause", 32'(fault_cause), 32'd2);
    chk("ill_ldst_req", 32'(mem_req), 32'd0);
    present(1'b0, 1'b1, 3'b100, 32'h300, 32'h0, 5'd9, 1'b1);
    step();
    idle_ex();
    chk("ill_st_cause", 32'(fault_cause), 32'd2);
    chk("ill_st_flt", 32'(fault_valid), 32'd1);

    // Ack in IDLE is ignored
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_wbv", 32'(wb_valid), 32'd0);
    chk("idle_ack_req", 32'(mem_req), 32'd0);

    // Timeout: mem_req high for four cycles, then cause 11
    present(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd3, 1'b1);
    step();
    idle_ex();
    chk("to_req1", 32'(mem_req), 32'd1);
    step(); chk("to_req2", 32'(mem_req), 32'd1);
    step(); chk("to_req3", 32'(mem_req), 32'd1);
    step(); chk("to_req4", 32'(mem_req), 32'd1);
    step();
    chk("to_reqdrop", 32'(mem_req), 32'd0);
    chk("to_flt", 32'(fault_valid), 32'd1);
    chk("to_cause", 32'(fault_cause), 32'd3);
    chk("to_addr", fault_addr, 32'h400);
    chk("to_wbwe", 32'(wb_we), 32'd0);
    chk("to_rdy", 32'(ex_ready), 32'd1);

    // Ack on the timeout cycle completes normally
    present(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 5'd3, 1'b1);
    step();
    idle_ex();
    step(); step(); step();
    chk("late_req4", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0001;
    step();
    mem_ack = 1'b0;
    chk("late_flt", 32'(fault_valid), 32'd0);
    chk("late_wbv", 32'(wb_valid), 32'd1);
    chk("late_wbwe", 32'(wb_we), 32'd1);
    chk("late_data", wb_data, 32'hA5A5_0001);

    // Reset while a request is outstanding
    present(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd4, 1'b1);
    step();
    idle_ex();
    chk("rr_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    step();
    chk("rr_reqdrop", 32'(mem_req), 32'd0);
    chk("rr_wbv", 32'(wb_valid), 32'd0);
    chk("rr_rdy_in_rst", 32'(ex_ready), 32'd0);
    rst = 1'b0; #1;
    chk("rr_rdy", 32'(ex_ready), 32'd1);
    step();
    chk("rr_no_wb", 32'(wb_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
